ppu_vram_arbiter: RTL and testbench
===================================

// Module: ppu_vram_arbiter
// PURPOSE
//  Shares the single PPU memory port (CHR ROM at $0000-$1FFF, nametable VRAM at $2000-$3FFF) between two requesters:
//  the background/sprite renderer fetch engine and CPU PPUDATA ($2007) accesses.
//  Sits between those requesters and the PPU memory wrapper. Memory read latency is 1 clk.
//  Renderer has priority; a starvation guard guarantees CPU service within MAX_WAIT cycles.
// PARAMETERS
//  ADDR_W    14  PPU address width
//  DATA_W    8   data width
//  MAX_WAIT  8   max cycles a pending CPU request may be blocked by the renderer before it is forced (>=1)
// PORTS
//  clk        in   1       PPU clock; single clock domain
//  rst        in   1       synchronous, active-high reset
//  rnd_req    in   1       renderer read request; held with rnd_addr until rnd_gnt
//  rnd_addr   in   ADDR_W  renderer read address
//  rnd_gnt    out  1       renderer request issued to memory this cycle
//  rnd_rvalid out  1       1-cycle pulse: rnd_rdata valid
//  rnd_rdata  out  DATA_W  renderer read data (= mem_q when rnd_rvalid)
//  cpu_req    in   1       CPU access request; accepted only when cpu_busy=0
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_busy   out  1       slot occupied (pending or read in flight)
//  cpu_done   out  1       1-cycle pulse: write issued, or read data valid
//  cpu_rdata  out  DATA_W  last CPU read data; held until next CPU read completes
//  mem_addr   out  ADDR_W  memory address
//  mem_wr     out  1       memory write strobe (memory ignores writes with addr[13]=0)
//  mem_wdata  out  DATA_W  memory write data
//  mem_q      in   DATA_W  memory read data, valid 1 clk after issue
// BEHAVIOUR
//  Reset: rnd_gnt=0, rnd_rvalid=0, rnd_rdata=0, cpu_busy=0, cpu_done=0, cpu_rdata=0, mem_addr=0, mem_wr=0, mem_wdata=0;
//   pending slot empty, wait counter=0, return tag=OWN_NONE. Reset mid-operation discards pending/in-flight requests, no done.
//  CPU slot FSM: EMPTY -> PEND on cpu_req & !cpu_busy (captures we/addr/wdata); cpu_req while busy is ignored.
//   PEND -> EMPTY when a write issues (cpu_done same cycle); PEND -> RD_WAIT when a read issues; RD_WAIT -> EMPTY next clk
//   with cpu_done=1, cpu_rdata<=mem_q. cpu_busy = (state != EMPTY).
//  Issue decision (combinational, per cycle): force = PEND & wait_cnt==MAX_WAIT.
//   force      -> CPU issues, rnd_gnt=0.
//   rnd_req    -> renderer issues, rnd_gnt=1; if PEND, wait_cnt++.
//   PEND       -> CPU issues.
//   else       -> idle: mem_wr=0, mem_addr holds previous value.
//  wait_cnt clears whenever the CPU issues; saturates at MAX_WAIT; width $clog2(MAX_WAIT+1).
//  Minimum CPU latency: req at N, issue at N+1; write done at N+1, read done at N+2.
//  mem_addr/mem_wr/mem_wdata driven combinationally from the issuing requester; mem_wr=1 only for CPU writes.
//  Return tag register records the owner of each issued read; next clk routes mem_q to rnd_rdata/rnd_rvalid or cpu_rdata/cpu_done.
//   Back-to-back issues every cycle are legal (tag is 1-deep, latency 1).
//  Renderer never observes a write; a renderer read following a CPU write at same addr sees the new data.
// STRUCTURE
//  ppu_mem_pkg: typedef enum {OWN_NONE, OWN_RND, OWN_CPU} owner_t; typedef enum {SLOT_EMPTY, SLOT_PEND, SLOT_RD_WAIT} cpu_slot_t;
//   constants PPU_ADDR_W=14, PPU_DATA_W=8, PPU_NT_BASE=14'h2000.
//  One sub-module: ppu_cpu_req_slot (slot FSM + captured request + wait counter); arbitration and return routing in the top.
// TESTING
//  1 CPU write alone: cpu_req, we=1, addr=14'h2005, wdata=8'hA5 at N -> mem_wr=1, mem_addr=14'h2005 at N+1, cpu_done at N+1.
//  2 CPU read alone after test 1: read 14'h2005 -> issue N+1, cpu_done N+2, cpu_rdata=8'hA5, cpu_busy low at N+3.
//  3 Renderer continuous rnd_req, CPU write pending, MAX_WAIT=8 -> CPU issues exactly 8 cycles after pending, rnd_gnt=0 that cycle only.
//  4 Interleaved reads: renderer reads 14'h0010, CPU reads 14'h2000 next cycle -> rnd_rvalid and cpu_done each once, correct data, no swap.
//  5 cpu_req while cpu_busy=1 (addr 14'h2100) -> ignored; no mem access to 14'h2100, single cpu_done for original request.
//  6 rst asserted while CPU read in flight -> no cpu_done, all outputs at reset values next clk, cpu_busy=0.

Source files
------------

// File: rtl/ppu_mem_pkg.sv
// ppu_mem_pkg: shared types and constants for the PPU memory port arbiter.
// Rev 1.0
`default_nettype none

package ppu_mem_pkg;

  localparam int PPU_ADDR_W = 14;
  localparam int PPU_DATA_W = 8;
  localparam logic [PPU_ADDR_W-1:0] PPU_NT_BASE = 14'h2000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RND  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_PEND    = 2'd1,
    SLOT_RD_WAIT = 2'd2
  } cpu_slot_t;

endpackage

`default_nettype wire

// File: rtl/ppu_cpu_req_slot.sv
// ppu_cpu_req_slot: single-entry CPU request holder with starvation wait counter.
// Rev 1.0
`default_nettype none

module ppu_cpu_req_slot
  import ppu_mem_pkg::*;
#(
  parameter int ADDR_W   = PPU_ADDR_W,
  parameter int DATA_W   = PPU_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              issue,
  input  logic              blocked,
  output logic              pend,
  output logic              busy,
  output logic              force_issue,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  cpu_slot_t         state_q;
  cpu_slot_t         state_d;
  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= SLOT_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY:   if (cpu_req) state_d = SLOT_PEND;
      SLOT_PEND:    if (issue)   state_d = we ? SLOT_EMPTY : SLOT_RD_WAIT;
      SLOT_RD_WAIT: state_d = SLOT_EMPTY;
      default:      state_d = SLOT_EMPTY;
    endcase
  end

  // Requests arriving while the slot is occupied are dropped, not queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else if (state_q == SLOT_EMPTY && cpu_req) begin
      we    <= cpu_we;
      addr  <= cpu_addr;
      wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || issue) begin
      wait_cnt <= '0;
    end else if (state_q == SLOT_PEND && blocked && wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign pend        = (state_q == SLOT_PEND);
  assign busy        = (state_q != SLOT_EMPTY);
  assign force_issue = pend && (wait_cnt == WAIT_LIMIT);

endmodule

`default_nettype wire

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the PPU memory port between renderer fetches and CPU PPUDATA.
// Rev 1.0
`default_nettype none

module ppu_vram_arbiter
  import ppu_mem_pkg::*;
#(
  parameter int ADDR_W   = PPU_ADDR_W,
  parameter int DATA_W   = PPU_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rnd_req,
  input  logic [ADDR_W-1:0] rnd_addr,
  output logic              rnd_gnt,
  output logic              rnd_rvalid,
  output logic [DATA_W-1:0] rnd_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);

  logic              slot_pend;
  logic              slot_force;
  logic              slot_we;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;
  logic              cpu_issue;
  logic              rnd_issue;
  logic              cpu_rd_done;
  owner_t            ret_tag;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] rnd_rdata_hold;
  logic [DATA_W-1:0] cpu_rdata_hold;

  ppu_cpu_req_slot #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_slot (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .issue      (cpu_issue),
    .blocked    (rnd_issue),
    .pend       (slot_pend),
    .busy       (cpu_busy),
    .force_issue(slot_force),
    .we         (slot_we),
    .addr       (slot_addr),
    .wdata      (slot_wdata)
  );

  // Renderer wins unless the CPU has been starved long enough to be forced.
  always_comb begin
    cpu_issue = 1'b0;
    rnd_issue = 1'b0;
    if (!rst) begin
      if (slot_force)     cpu_issue = 1'b1;
      else if (rnd_req)   rnd_issue = 1'b1;
      else if (slot_pend) cpu_issue = 1'b1;
    end
  end

  assign rnd_gnt   = rnd_issue;
  assign mem_addr  = cpu_issue ? slot_addr : (rnd_issue ? rnd_addr : addr_hold);
  assign mem_wr    = cpu_issue && slot_we;
  assign mem_wdata = mem_wr ? slot_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_tag        <= OWN_NONE;
      addr_hold      <= '0;
      rnd_rdata_hold <= '0;
      cpu_rdata_hold <= '0;
    end else begin
      addr_hold <= mem_addr;
      if (rnd_issue)                  ret_tag <= OWN_RND;
      else if (cpu_issue && !slot_we) ret_tag <= OWN_CPU;
      else                            ret_tag <= OWN_NONE;
      if (ret_tag == OWN_RND) rnd_rdata_hold <= mem_q;
      if (ret_tag == OWN_CPU) cpu_rdata_hold <= mem_q;
    end
  end

  // A reset in the return cycle swallows the response.
  assign rnd_rvalid  = !rst && (ret_tag == OWN_RND);
  assign cpu_rd_done = !rst && (ret_tag == OWN_CPU);
  assign rnd_rdata   = rnd_rvalid  ? mem_q : rnd_rdata_hold;
  assign cpu_rdata   = cpu_rd_done ? mem_q : cpu_rdata_hold;
  assign cpu_done    = mem_wr || cpu_rd_done;

endmodule

`default_nettype wire

// File: tb/tb_ppu_vram_arbiter.sv
// tb_ppu_vram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Rev 1.0
`default_nettype none

module tb_ppu_vram_arbiter;
  import ppu_mem_pkg::*;

  localparam int MAXW = 8;

  logic        clk;
  logic        rst;
  logic        rnd_req;
  logic [13:0] rnd_addr;
  logic        rnd_gnt;
  logic        rnd_rvalid;
  logic [7:0]  rnd_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [7:0]  cpu_rdata;
  logic [13:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_q;

  int total = 0;
  int bad   = 0;

  logic [7:0] salt;
  logic [7:0] vram       [0:16383];
  bit         vram_valid [0:16383];
  logic [7:0] shadow_w   [logic [13:0]];

  ppu_vram_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_gnt(rnd_gnt),
    .rnd_rvalid(rnd_rvalid), .rnd_rdata(rnd_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [13:0] a);
    return a[7:0] ^ (8'(a[13:8]) * 8'd29) ^ salt;
  endfunction

  function automatic logic [7:0] mem_exp(input logic [13:0] a);
    if (shadow_w.exists(a)) return shadow_w[a];
    return init_byte(a);
  endfunction

  function automatic logic [13:0] pick_addr();
    logic       hi;
    logic [3:0] lo;
    hi = 1'($urandom_range(0, 1));
    lo = 4'($urandom_range(0, 15));
    return {hi, 9'd0, lo};
  endfunction

  // External memory: 1-clock read latency, CHR region is read-only.
  always @(posedge clk) begin
    if (mem_wr && mem_addr >= PPU_NT_BASE) begin
      vram[mem_addr]       <= mem_wdata;
      vram_valid[mem_addr] <= 1'b1;
    end
    mem_q <= vram_valid[mem_addr] ? vram[mem_addr] : init_byte(mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rnd_req = 1'b0; rnd_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step(); step();
    @(negedge clk);
    total++; if (rnd_gnt !== 1'b0)    begin bad++; $display("FAIL rst_rnd_gnt: got %b want 0", rnd_gnt); end
    total++; if (rnd_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rnd_rvalid: got %b want 0", rnd_rvalid); end
    total++; if (rnd_rdata !== 8'h00) begin bad++; $display("FAIL rst_rnd_rdata: got %h want 00", rnd_rdata); end
    total++; if (cpu_busy !== 1'b0)   begin bad++; $display("FAIL rst_cpu_busy: got %b want 0", cpu_busy); end
    total++; if (cpu_done !== 1'b0)   begin bad++; $display("FAIL rst_cpu_done: got %b want 0", cpu_done); end
    total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
    total++; if (mem_addr !== 14'h0)  begin bad++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    total++; if (mem_wr !== 1'b0)     begin bad++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
    total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL rst_mem_wdata: got %h want 00", mem_wdata); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2005; cpu_wdata = 8'hA5;
    @(negedge clk);
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL wr_early_memwr: got %b want 0", mem_wr); end
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    total++; if (mem_wr !== 1'b1)        begin bad++; $display("FAIL wr_mem_wr: got %b want 1", mem_wr); end
    total++; if (mem_addr !== 14'h2005)  begin bad++; $display("FAIL wr_mem_addr: got %h want 2005", mem_addr); end
    total++; if (mem_wdata !== 8'hA5)    begin bad++; $display("FAIL wr_mem_wdata: got %h want a5", mem_wdata); end
    total++; if (cpu_done !== 1'b1)      begin bad++; $display("FAIL wr_done: got %b want 1", cpu_done); end
    shadow_w[14'h2005] = 8'hA5;
    step();
    @(negedge clk);
    total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL wr_done_pulse: got %b want 0", cpu_done); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after: got %b want 0", cpu_busy); end
    step();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2005; cpu_wdata = 8'h00;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    total++; if (mem_addr !== 14'h2005) begin bad++; $display("FAIL rd_mem_addr: got %h want 2005", mem_addr); end
    total++; if (mem_wr !== 1'b0)       begin bad++; $display("FAIL rd_mem_wr: got %b want 0", mem_wr); end
    total++; if (cpu_done !== 1'b0)     begin bad++; $display("FAIL rd_done_early: got %b want 0", cpu_done); end
    step();
    @(negedge clk);
    total++; if (cpu_done !== 1'b1)   begin bad++; $display("FAIL rd_done: got %b want 1", cpu_done); end
    total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", cpu_rdata); end
    total++; if (cpu_busy !== 1'b1)   begin bad++; $display("FAIL rd_busy_wait: got %b want 1", cpu_busy); end
    step();
    @(negedge clk);
    total++; if (cpu_busy !== 1'b0)   begin bad++; $display("FAIL rd_busy_after: got %b want 0", cpu_busy); end
    total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data_hold: got %h want a5", cpu_rdata); end
    step();
  endtask

  task automatic test_starvation();
    rnd_req = 1'b1; rnd_addr = 14'h0100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2010; cpu_wdata = 8'h3C;
    step();
    cpu_req = 1'b0;
    for (int k = 0; k < MAXW + 2; k++) begin
      @(negedge clk);
      total++;
      if (rnd_gnt !== (k != MAXW)) begin
        bad++; $display("FAIL starve_gnt[%0d]: got %b want %b", k, rnd_gnt, (k != MAXW));
      end
      if (k == MAXW) begin
        total++;
        if (mem_wr !== 1'b1 || mem_addr !== 14'h2010 || cpu_done !== 1'b1) begin
          bad++; $display("FAIL starve_force: got wr=%b addr=%h done=%b want 1/2010/1", mem_wr, mem_addr, cpu_done);
        end
      end
      step();
    end
    shadow_w[14'h2010] = 8'h3C;
    rnd_req = 1'b0;
    step();
  endtask

  task automatic test_interleave();
    int nr = 0;
    int nc = 0;
    rnd_req = 1'b1; rnd_addr = 14'h0010;
    @(negedge clk);
    total++; if (rnd_gnt !== 1'b1) begin bad++; $display("FAIL il_gnt: got %b want 1", rnd_gnt); end
    step();
    rnd_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rnd_rvalid === 1'b1) begin
        nr++;
        total++; if (rnd_rdata !== mem_exp(14'h0010)) begin bad++; $display("FAIL il_rnd_data: got %h want %h", rnd_rdata, mem_exp(14'h0010)); end
      end
      if (cpu_done === 1'b1) begin
        nc++;
        total++; if (cpu_rdata !== mem_exp(14'h2000)) begin bad++; $display("FAIL il_cpu_data: got %h want %h", cpu_rdata, mem_exp(14'h2000)); end
      end
      step();
      cpu_req = 1'b0;
    end
    total++; if (nr !== 1) begin bad++; $display("FAIL il_rvalid_cnt: got %0d want 1", nr); end
    total++; if (nc !== 1) begin bad++; $display("FAIL il_done_cnt: got %0d want 1", nc); end
  endtask

  task automatic test_busy_ignore();
    int nd = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2020;
    step();
    for (int k = 0; k < 5; k++) begin
      cpu_req = (k < 2); cpu_we = 1'b1; cpu_addr = 14'h2100; cpu_wdata = 8'h77;
      @(negedge clk);
      if (k < 2) begin
        total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL ign_busy[%0d]: got %b want 1", k, cpu_busy); end
      end
      total++; if (mem_addr === 14'h2100) begin bad++; $display("FAIL ign_addr[%0d]: got %h want not 2100", k, mem_addr); end
      if (cpu_done === 1'b1) nd++;
      step();
    end
    total++; if (nd !== 1) begin bad++; $display("FAIL ign_done_cnt: got %0d want 1", nd); end
  endtask

  task automatic test_reset_inflight();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2005;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    total++; if (mem_addr !== 14'h2005) begin bad++; $display("FAIL rif_issue: got %h want 2005", mem_addr); end
    step();
    rst = 1'b1;
    @(negedge clk);
    total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL rif_done: got %b want 0", cpu_done); end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_busy !== 1'b0 || cpu_done !== 1'b0 || cpu_rdata !== 8'h00 || mem_wr !== 1'b0 ||
        mem_addr !== 14'h0 || rnd_rvalid !== 1'b0 || rnd_rdata !== 8'h00 || rnd_gnt !== 1'b0 ||
        mem_wdata !== 8'h00) begin
      bad++;
      $display("FAIL rif_outputs: got busy=%b done=%b rdata=%h wr=%b addr=%h rv=%b rr=%h gnt=%b wd=%h want all 0",
               cpu_busy, cpu_done, cpu_rdata, mem_wr, mem_addr, rnd_rvalid, rnd_rdata, rnd_gnt, mem_wdata);
    end
    step();
  endtask

  task automatic test_random(input int cycles);
    bit          pend = 0, rd_inf = 0, rnd_inf = 0, last_gnt = 0;
    bit          p_we = 0;
    logic [13:0] p_addr = '0;
    logic [7:0]  p_wdata = '0, rd_exp = '0, rnd_exp = '0, held = 8'h00;
    int          age = 0;
    bit          e_force, e_cpu, e_rnd, e_busy, e_done;
    for (int c = 0; c < cycles; c++) begin
      if (!(rnd_req && !last_gnt)) begin
        rnd_req  = ($urandom_range(0, 99) < 60);
        rnd_addr = pick_addr();
      end
      cpu_req   = ($urandom_range(0, 99) < 35);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = pick_addr();
      cpu_wdata = 8'($urandom);
      @(negedge clk);
      e_force = pend && (age >= MAXW);
      e_cpu   = pend && (e_force || !rnd_req);
      e_rnd   = rnd_req && !e_force;
      e_busy  = pend || rd_inf;
      e_done  = (e_cpu && p_we) || rd_inf;
      if (rd_inf) held = rd_exp;
      total++; if (rnd_gnt !== e_rnd)        begin bad++; $display("FAIL rand_gnt@%0d: got %b want %b", c, rnd_gnt, e_rnd); end
      total++; if (cpu_busy !== e_busy)      begin bad++; $display("FAIL rand_busy@%0d: got %b want %b", c, cpu_busy, e_busy); end
      total++; if (cpu_done !== e_done)      begin bad++; $display("FAIL rand_done@%0d: got %b want %b", c, cpu_done, e_done); end
      total++; if (mem_wr !== (e_cpu && p_we)) begin bad++; $display("FAIL rand_wr@%0d: got %b want %b", c, mem_wr, e_cpu && p_we); end
      total++; if (rnd_rvalid !== rnd_inf)   begin bad++; $display("FAIL rand_rvalid@%0d: got %b want %b", c, rnd_rvalid, rnd_inf); end
      total++; if (cpu_rdata !== held)       begin bad++; $display("FAIL rand_cpu_rdata@%0d: got %h want %h", c, cpu_rdata, held); end
      if (e_cpu) begin
        total++; if (mem_addr !== p_addr) begin bad++; $display("FAIL rand_cpu_addr@%0d: got %h want %h", c, mem_addr, p_addr); end
        if (p_we) begin
          total++; if (mem_wdata !== p_wdata) begin bad++; $display("FAIL rand_wdata@%0d: got %h want %h", c, mem_wdata, p_wdata); end
        end
      end else if (e_rnd) begin
        total++; if (mem_addr !== rnd_addr) begin bad++; $display("FAIL rand_rnd_addr@%0d: got %h want %h", c, mem_addr, rnd_addr); end
      end
      if (rnd_inf) begin
        total++; if (rnd_rdata !== rnd_exp) begin bad++; $display("FAIL rand_rnd_data@%0d: got %h want %h", c, rnd_rdata, rnd_exp); end
      end
      @(posedge clk);
      rnd_inf  = e_rnd;
      if (e_rnd) rnd_exp = mem_exp(rnd_addr);
      rd_inf   = e_cpu && !p_we;
      if (rd_inf) rd_exp = mem_exp(p_addr);
      if (e_cpu && p_we && p_addr >= PPU_NT_BASE) shadow_w[p_addr] = p_wdata;
      last_gnt = e_rnd;
      if (e_cpu) pend = 0;
      else if (pend) age++;
      if (cpu_req && !e_busy) begin
        pend = 1; age = 0; p_we = cpu_we; p_addr = cpu_addr; p_wdata = cpu_wdata;
      end
      #1;
    end
    rnd_req = 1'b0; cpu_req = 1'b0;
    step(); step();
  endtask

  initial begin
    salt = 8'($urandom);
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_starvation();
    test_interleave();
    test_busy_ignore();
    test_reset_inflight();
    test_random(500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
